// File: rtl/kgp_pc_pkg.sv
// Shared definitions for the PC fetch controller: default widths, reset PC
// and the fetch FSM state encoding.
package kgp_pc_pkg;

    // Default PC / instruction-address width
    localparam int DEF_PC_W = 10;

    // Default PC loaded on reset
    localparam int DEF_RESET_PC = 0;

    // Fetch sequencer states (encoding is visible on the debug state port)
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage : kgp_pc_pkg

// File: rtl/pc_fetch_ctrl_ras_stack.sv
// Return-address stack with circular overwrite: a push while full replaces
// the oldest entry and flags overflow; a pop while empty flags underflow.
// Top-of-stack is read combinationally so ra follows the stack directly.
module ras_stack #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic [AW-1:0]   wr_idx;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;

    // Next slot after the top; when full this is the oldest entry
    assign wr_idx = ptr_q + 1'b1;
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign top    = empty ? '0 : mem_q[ptr_q];
    assign ovf    = ovf_q;
    assign unf    = unf_q;

    // One register per stack slot, written only when a push targets it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_idx == AW'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointer, occupancy and sticky error flags for the next cycle
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            ptr_d = wr_idx;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    // Stack bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule : ras_stack

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: owns the architectural PC, sequences fetch, applies
// taken-branch redirects with a flush bubble, and tracks return addresses.
// Build option KGP_RAS_EN: when defined a RAS_DEPTH-entry return-address
// stack is used; otherwise a single return-address register stands in.
module pc_fetch_ctrl
    import kgp_pc_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int RESET_PC     = DEF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic [31:0]     ra,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf,
    output logic [1:0]      state
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    // Reject configurations the datapath cannot represent
    generate
        if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("RAS_DEPTH must be a power of two and at least 2");
        end
        if (FLUSH_CYCLES < 1) begin : g_bad_flush
            $error("FLUSH_CYCLES must be at least 1");
        end
    endgenerate

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic            accept;
    logic            ras_push;
    logic [PC_W-1:0] push_addr;
    logic [PC_W-1:0] ras_top;

    // A redirect is taken only in RUN/FLUSH and only when halt is not asserted
    assign accept    = ((state_q == RUN) || (state_q == FLUSH)) && !halt && redirect_valid;
    assign ras_push  = accept && is_call && !is_ret;
    assign push_addr = redirect_pc + 1'b1;

`ifdef KGP_RAS_EN
    logic ras_pop;

    assign ras_pop = accept && is_ret;

    ras_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (push_addr),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );
`else
    logic [PC_W-1:0] ra_q;
    logic [PC_W-1:0] ra_d;
    logic            ra_set_q;
    logic            ra_set_d;

    // Single return-address register: a call overwrites it, a return reads it
    always_comb begin
        ra_d     = ra_q;
        ra_set_d = ra_set_q;
        if (ras_push) begin
            ra_d     = push_addr;
            ra_set_d = 1'b1;
        end
    end

    // Return-address register and its "written at least once" flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q     <= '0;
            ra_set_q <= 1'b0;
        end else begin
            ra_q     <= ra_d;
            ra_set_q <= ra_set_d;
        end
    end

    assign ras_top   = ra_q;
    assign ras_empty = !ra_set_q;
    assign ras_full  = ra_set_q;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    // Next-state logic: halt > redirect > stall > increment while running
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, FLUSH: begin
                if (halt) begin
                    state_d = HALT;
                end else if (redirect_valid) begin
                    pc_d    = is_ret ? ras_top : redirect_target;
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else if (state_q == FLUSH) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // FSM, PC and flush counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= PC_W'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN) && !stall;
    assign ra          = 32'(ras_top);
    assign state       = state_q;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed sequences plus random stimulus,
// expected outputs come from a queue-based behavioural model of the PC/RAS.
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;
    localparam int FLUSH = 1;
    localparam int PCN   = 1 << PC_W;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            halt;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic [PC_W-1:0] redirect_pc;
    logic            is_call;
    logic            is_ret;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic [31:0]     ra;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;
    logic [1:0]      state;

    pc_fetch_ctrl #(
        .PC_W         (PC_W),
        .RAS_DEPTH    (DEPTH),
        .FLUSH_CYCLES (FLUSH),
        .RESET_PC     (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_pc     (redirect_pc),
        .is_call         (is_call),
        .is_ret          (is_ret),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .ra              (ra),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ras_ovf         (ras_ovf),
        .ras_unf         (ras_unf),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int fv;
        int ra;
        int empty;
        int full;
        int ovf;
        int unf;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // Behavioural model: 0=BOOT 1=RUN 2=FLUSH 3=HALT
    bit   m_known = 0;
    int   m_state;
    int   m_pc;
    int   m_left;
    int   m_ras[$];     // newest entry at the back
    int   m_ovf;
    int   m_unf;
    int   m_ra;         // single-register variant
    int   m_ra_set;

    function automatic exp_t model_outputs(input bit s);
        exp_t e;
        e.pc = m_pc;
        e.fv = (m_state == 1 && !s) ? 1 : 0;
        e.st = m_state;
`ifdef KGP_RAS_EN
        e.ra    = (m_ras.size() > 0) ? m_ras[m_ras.size() - 1] : 0;
        e.empty = (m_ras.size() == 0) ? 1 : 0;
        e.full  = (m_ras.size() == DEPTH) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
`else
        e.ra    = m_ra;
        e.empty = m_ra_set ? 0 : 1;
        e.full  = m_ra_set;
        e.ovf   = 0;
        e.unf   = 0;
`endif
        return e;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit h, input bit rv,
                              input int tgt, input int rpc, input bit c, input bit rt);
        int target;
        if (r) begin
            m_known  = 1;
            m_state  = 0;
            m_pc     = 0;
            m_left   = 0;
            m_ras.delete();
            m_ovf    = 0;
            m_unf    = 0;
            m_ra     = 0;
            m_ra_set = 0;
            return;
        end
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 || m_state == 2) begin
            if (h) begin
                m_state = 3;
            end else if (rv) begin
                if (rt) begin
`ifdef KGP_RAS_EN
                    if (m_ras.size() == 0) begin
                        target = 0;
                        m_unf  = 1;
                    end else begin
                        target = m_ras.pop_back();
                    end
`else
                    target = m_ra;
`endif
                end else begin
                    target = tgt;
                    if (c) begin
`ifdef KGP_RAS_EN
                        if (m_ras.size() == DEPTH) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                        m_ras.push_back((rpc + 1) % PCN);
`else
                        m_ra     = (rpc + 1) % PCN;
                        m_ra_set = 1;
`endif
                    end
                end
                m_pc    = target;
                m_state = 2;
                m_left  = FLUSH;
            end else if (m_state == 2) begin
                if (m_left == 1) m_state = 1;
                else m_left = m_left - 1;
            end else if (!s) begin
                m_pc = (m_pc + 1) % PCN;
            end
        end
    endtask

    // One clock of stimulus: drive inputs, queue the expected outputs, advance model
    task automatic cyc(input bit r, input bit s, input bit h, input bit rv,
                       input int tgt, input int rpc, input bit c, input bit rt);
        @(posedge clk);
        #1;
        rst             = r;
        stall           = s;
        halt            = h;
        redirect_valid  = rv;
        redirect_target = PC_W'(tgt);
        redirect_pc     = PC_W'(rpc);
        is_call         = c;
        is_ret          = rt;
        if (m_known) exp_q.push_back(model_outputs(s));
        model_step(r, s, h, rv, tgt, rpc, c, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic void check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, ncyc);
        end
    endfunction

    // Monitor: pops one expectation per observed cycle and compares on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncyc++;
            $display("cyc %0d pc=%03h fv=%0b ra=%03h empty=%0b full=%0b ovf=%0b unf=%0b st=%0d",
                     ncyc, pc, fetch_valid, ra, ras_empty, ras_full, ras_ovf, ras_unf, state);
            check("pc",          int'(pc),          e.pc);
            check("fetch_valid", int'(fetch_valid), e.fv);
            check("ra",          int'(ra),          e.ra);
            check("ras_empty",   int'(ras_empty),   e.empty);
            check("ras_full",    int'(ras_full),    e.full);
            check("ras_ovf",     int'(ras_ovf),     e.ovf);
            check("ras_unf",     int'(ras_unf),     e.unf);
            check("state",       int'(state),       e.st);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        halt            = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        redirect_pc     = '0;
        is_call         = 1'b0;
        is_ret          = 1'b0;

        // Reset, boot, then sequential fetch 0..4 and on to pc=10
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(11);
        // Redirect at pc=10 to 0x080, one bubble, then fetch from the target
        cyc(0, 0, 0, 1, 'h080, 10, 0, 0);
        idle(3);
        // Wrap: land on 0x3FE and run across 1023 -> 0
        cyc(0, 0, 0, 1, 'h3FE, 'h083, 0, 0);
        idle(5);
        // Stall holds pc and drops fetch_valid
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Call then return
        cyc(0, 0, 0, 1, 'h100, 'h020, 1, 0);
        idle(3);
        cyc(0, 0, 0, 1, 'h3AA, 'h102, 0, 1);
        idle(3);
        // Five calls into a four-deep stack, then five returns
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 'h200 + 16 * k, 'h040 + k, 1, 0);
            idle(1);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 'h155, 'h300 + k, 0, 1);
            idle(1);
        end
        // Redirect during flush restarts it; call+ret together acts as ret only
        cyc(0, 0, 0, 1, 'h050, 'h010, 1, 0);
        cyc(0, 0, 0, 1, 'h060, 'h051, 1, 1);
        idle(2);
        // Halt beats a same-cycle redirect; everything ignored until reset
        cyc(0, 0, 1, 1, 'h1F0, 'h070, 1, 0);
        cyc(0, 0, 0, 1, 'h1F1, 'h071, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom % 120) == 0;
            if (m_state == 3 && ($urandom % 4) == 0) r = 1'b1;
            cyc(r,
                ($urandom % 4) == 0,
                ($urandom % 80) == 0,
                ($urandom % 4) == 0,
                int'($urandom % PCN),
                int'($urandom % PCN),
                ($urandom % 2) == 1,
                ($urandom % 3) == 0);
        end
        idle(2);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
